// File: rtl/dma_axi_mem_slave_pkg.sv
// Shared definitions for the AXI4 burst slave memory: burst/response encodings,
// channel FSM states and the request legality check.
package dma_axi_mem_slave_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // WRAP and reserved bursts, and beats wider than 32 bits, are never served.
    function automatic logic cfg_error(input logic [1:0] burst, input logic [2:0] size);
        return (burst == AXI_BURST_WRAP) || (burst == 2'b11) || (size > 3'd2);
    endfunction

endpackage

// File: rtl/dma_axi_mem_ram.sv
// Word-addressed RAM: one byte-enabled write port and one registered read port.
// A read and a write to the same word in one cycle return the old contents.
module dma_axi_mem_ram
    import dma_axi_mem_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dma_axi_mem_slave.sv
// AXI4 burst slave memory terminating the DMA master port. Read and write
// channels run independent FSMs with one outstanding burst per direction.
module dma_axi_mem_slave
    import dma_axi_mem_slave_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int unsigned         IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * 4);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a - BASE_ADDR} < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0]            size,
                                                        input logic [1:0]            burst);
        if (burst == AXI_BURST_FIXED) begin
            return a;
        end
        return a + (ADDR_WIDTH'(1) << size);
    endfunction

    wr_state_t             w_state;
    logic                  aw_ready;
    logic                  w_ready;
    logic                  b_valid;
    logic [1:0]            b_resp;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [7:0]            w_cnt;
    logic                  w_cfg_err;
    logic                  w_err;
    logic                  w_over;
    logic                  w_beat_bad;

    rd_state_t             r_state;
    logic                  ar_ready;
    logic                  r_valid;
    logic                  r_last;
    logic [1:0]            r_resp;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  r_cfg_err;
    logic                  r_next_err;

    logic                  ram_we;
    logic                  ram_re;
    logic [IDX_W-1:0]      ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Beats past AWLEN (w_over) are accepted but never reach the RAM.
    always_comb begin
        w_beat_bad = w_cfg_err || !in_range(w_addr) || w_over;
        ram_we     = (w_state == W_DATA) && S_AXI_WVALID && !w_beat_bad;
    end

    // The RAM read is issued on the handshake so the beat is ready one cycle later.
    always_comb begin
        ram_re     = 1'b0;
        ram_raddr  = word_idx(r_addr);
        r_next_err = r_cfg_err || !in_range(r_addr);
        if (r_state == R_IDLE) begin
            ram_re    = S_AXI_ARVALID;
            ram_raddr = word_idx(S_AXI_ARADDR);
        end else begin
            ram_re = S_AXI_RREADY && !r_last;
        end
    end

    dma_axi_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_idx(w_addr)),
        .wdata (S_AXI_WDATA),
        .wstrb (S_AXI_WSTRB),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_ready  <= 1'b1;
            w_ready   <= 1'b0;
            b_valid   <= 1'b0;
            b_resp    <= AXI_RESP_OKAY;
            w_addr    <= '0;
            w_len     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_cnt     <= '0;
            w_cfg_err <= 1'b0;
            w_err     <= 1'b0;
            w_over    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (S_AXI_AWVALID) begin
                        w_addr    <= S_AXI_AWADDR;
                        w_len     <= S_AXI_AWLEN;
                        w_size    <= S_AXI_AWSIZE;
                        w_burst   <= S_AXI_AWBURST;
                        w_cnt     <= '0;
                        w_cfg_err <= cfg_error(S_AXI_AWBURST, S_AXI_AWSIZE);
                        w_err     <= 1'b0;
                        w_over    <= 1'b0;
                        aw_ready  <= 1'b0;
                        w_ready   <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        if (S_AXI_WLAST) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_resp  <= (w_err || w_beat_bad || (w_cnt != w_len))
                                       ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_err <= w_err || w_beat_bad;
                            if (w_cnt == w_len) begin
                                w_over <= 1'b1;
                            end else begin
                                w_cnt <= w_cnt + 8'd1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        b_valid  <= 1'b0;
                        b_resp   <= AXI_RESP_OKAY;
                        aw_ready <= 1'b1;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // r_addr always holds the address of the beat to be fetched next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            ar_ready  <= 1'b1;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_resp    <= AXI_RESP_OKAY;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_len     <= S_AXI_ARLEN;
                        r_size    <= S_AXI_ARSIZE;
                        r_burst   <= S_AXI_ARBURST;
                        r_cfg_err <= cfg_error(S_AXI_ARBURST, S_AXI_ARSIZE);
                        r_addr    <= next_addr(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST);
                        r_cnt     <= '0;
                        r_err     <= cfg_error(S_AXI_ARBURST, S_AXI_ARSIZE) ||
                                     !in_range(S_AXI_ARADDR);
                        r_resp    <= (cfg_error(S_AXI_ARBURST, S_AXI_ARSIZE) ||
                                      !in_range(S_AXI_ARADDR))
                                     ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        r_last    <= (S_AXI_ARLEN == 8'd0);
                        r_valid   <= 1'b1;
                        ar_ready  <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_resp   <= AXI_RESP_OKAY;
                            r_err    <= 1'b0;
                            ar_ready <= 1'b1;
                            r_state  <= R_IDLE;
                        end else begin
                            r_addr <= next_addr(r_addr, r_size, r_burst);
                            r_cnt  <= r_cnt + 8'd1;
                            r_last <= (r_cnt + 8'd1 == r_len);
                            r_err  <= r_next_err;
                            r_resp <= r_next_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RLAST   = r_last;
    assign S_AXI_RRESP   = r_resp;
    assign S_AXI_RDATA   = (r_valid && !r_err) ? ram_rdata : '0;

endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Scoreboard bench for dma_axi_mem_slave: a shadow memory predicts read beats
// and write responses, which are queued and compared as the DUT responds.
module tb_dma_axi_mem_slave;

    localparam int unsigned MW   = 256;
    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam logic [31:0] TOP  = BASE + MW * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    dma_axi_mem_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_WORDS  (MW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWSIZE  (awsize),
        .S_AXI_AWBURST (awburst),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WLAST   (wlast),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] shadow [int unsigned];
    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] wd [32];
    logic [3:0]  ws [32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit inr(input logic [31:0] a);
        return (a >= BASE) && (a < TOP);
    endfunction

    function automatic int unsigned idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size,
                                         input logic [1:0] burst);
        if (burst == 2'b00) return a;
        return a + (32'd1 << size);
    endfunction

    // Caller is at a negedge; wd/ws hold the beats, nbeats-1 is where WLAST goes.
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int nbeats, input string tag);
        logic [31:0] a;
        logic [31:0] w;
        logic [1:0]  eb;
        bit          cfg;
        bit          err;
        bit          bad;
        int          t;
        a   = addr;
        cfg = burst[1] || (size > 3'd2);
        err = cfg;
        for (int i = 0; i < nbeats; i++) begin
            bad = cfg || !inr(a) || (i > int'(len));
            if (!bad) begin
                w = shadow.exists(idx(a)) ? shadow[idx(a)] : 32'h0;
                for (int b = 0; b < 4; b++) if (ws[i][b]) w[b*8 +: 8] = wd[i][b*8 +: 8];
                shadow[idx(a)] = w;
            end
            err = err || bad;
            a   = step(a, size, burst);
        end
        if (nbeats - 1 != int'(len)) err = 1'b1;
        bq.push_back(err ? 2'b10 : 2'b00);

        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        if (!awready) check({tag, " aw timeout"}, 0, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (!wready) check({tag, " w timeout"}, 0, 1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        eb = bq.pop_front();
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (!bvalid) check({tag, " b timeout"}, 0, 1);
        else         check({tag, " bresp"}, 64'(bresp), 64'(eb));
        @(negedge clk);
        bready = 1'b0;
        check({tag, " bvalid drop"}, 64'(bvalid), 0);
        check({tag, " awready back"}, 64'(awready), 1);
    endtask

    // stall=1 toggles RREADY every cycle; the front beat is compared every valid cycle.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input bit stall, input string tag);
        logic [31:0] a;
        rbeat_t      e;
        bit          cfg;
        bit          ph;
        int          t;
        a   = addr;
        cfg = burst[1] || (size > 3'd2);
        for (int i = 0; i <= int'(len); i++) begin
            if (cfg || !inr(a)) begin
                e.data = 32'h0; e.resp = 2'b10;
            end else begin
                e.data = shadow[idx(a)]; e.resp = 2'b00;
            end
            e.last = (i == int'(len));
            rq.push_back(e);
            a = step(a, size, burst);
        end

        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (!arready) check({tag, " ar timeout"}, 0, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check({tag, " rvalid latency"}, 64'(rvalid), 1);
        ph = 1'b0;
        t  = 0;
        while (rq.size() > 0 && rvalid && t < 600) begin
            rready = stall ? ph : 1'b1;
            ph     = ~ph;
            check({tag, " rdata"}, 64'(rdata), 64'(rq[0].data));
            check({tag, " rresp"}, 64'(rresp), 64'(rq[0].resp));
            check({tag, " rlast"}, 64'(rlast), 64'(rq[0].last));
            if (rready) void'(rq.pop_front());
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        if (rq.size() > 0) begin
            check({tag, " beats missing"}, 64'(rq.size()), 0);
            rq.delete();
        end
        check({tag, " rvalid drop"}, 64'(rvalid), 0);
        check({tag, " arready back"}, 64'(arready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst awready", 64'(awready), 1);
        check("rst arready", 64'(arready), 1);
        check("rst wready", 64'(wready), 0);
        check("rst bvalid", 64'(bvalid), 0);
        check("rst rvalid", 64'(rvalid), 0);
        check("rst rlast", 64'(rlast), 0);
        check("rst bresp", 64'(bresp), 0);
        check("rst rresp", 64'(rresp), 0);
        check("rst rdata", 64'(rdata), 0);
        rst = 1'b0;
        @(negedge clk);

        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        write_burst(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1, "single");
        read_burst(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1'b0, "single");

        for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        write_burst(BASE + 32'h100, 8'd15, 3'd2, 2'b01, 16, "incr16");
        read_burst(BASE + 32'h100, 8'd15, 3'd2, 2'b01, 1'b0, "incr16");
        read_burst(BASE + 32'h100, 8'd15, 3'd2, 2'b01, 1'b1, "stall16");

        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        write_burst(BASE + 32'h40, 8'd0, 3'd2, 2'b01, 1, "strb pre");
        wd[0] = 32'h1234_5678; ws[0] = 4'b0011;
        write_burst(BASE + 32'h40, 8'd0, 3'd2, 2'b01, 1, "strb low");
        read_burst(BASE + 32'h40, 8'd0, 3'd2, 2'b01, 1'b0, "strb low");

        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(BASE + 32'h50, 8'd1, 3'd1, 2'b01, 2, "narrow");
        read_burst(BASE + 32'h50, 8'd1, 3'd1, 2'b01, 1'b0, "narrow");

        wd[0] = 32'hA5A5_0001; wd[1] = 32'hA5A5_0002;
        write_burst(TOP - 32'd4, 8'd1, 3'd2, 2'b01, 2, "edge");
        read_burst(TOP - 32'd4, 8'd1, 3'd2, 2'b01, 1'b0, "edge");

        wd[0] = 32'hBAD0_BAD0; ws[0] = 4'hF;
        write_burst(BASE + 32'h10, 8'd0, 3'd2, 2'b10, 1, "wrapburst");
        read_burst(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1'b0, "wrap unchanged");
        read_burst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 1'b0, "size3 read");

        for (int i = 0; i < 4; i++) begin wd[i] = 32'h5500_0000 + 32'(i); ws[i] = 4'hF; end
        write_burst(BASE + 32'h200, 8'd3, 3'd2, 2'b01, 2, "early wlast");

        wd[0] = 32'h77; ws[0] = 4'hF;
        write_burst(BASE + 32'h308, 8'd0, 3'd2, 2'b01, 1, "over pre");
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        write_burst(BASE + 32'h300, 8'd1, 3'd2, 2'b01, 3, "overrun");
        read_burst(BASE + 32'h300, 8'd2, 3'd2, 2'b01, 1'b0, "overrun");

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hF1F0_0000 + 32'(i); ws[i] = 4'hF; end
        write_burst(BASE + 32'h20, 8'd3, 3'd2, 2'b00, 4, "fixed");
        read_burst(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 1'b0, "fixed");

        for (int i = 0; i < 8; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i); ws[i] = 4'hF; end
        write_burst(BASE + 32'h180, 8'd7, 3'd2, 2'b01, 8, "rst pre");
        araddr = BASE + 32'h180; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (!arready) check("rst mid ar timeout", 0, 1);
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst mid rvalid before", 64'(rvalid), 1);
        rst = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rst mid rvalid", 64'(rvalid), 0);
        check("rst mid arready", 64'(arready), 1);
        check("rst mid rlast", 64'(rlast), 0);
        check("rst mid rdata", 64'(rdata), 0);
        rst = 1'b0;
        @(negedge clk);
        read_burst(BASE + 32'h180, 8'd7, 3'd2, 2'b01, 1'b0, "after rst");

        for (int i = 0; i < 4; i++) begin wd[i] = 32'h0C0C_0000 + 32'(i); ws[i] = 4'hF; end
        fork
            write_burst(BASE + 32'h380, 8'd3, 3'd2, 2'b01, 4, "conc wr");
            read_burst(BASE + 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, "conc rd");
        join
        read_burst(BASE + 32'h380, 8'd3, 3'd2, 2'b01, 1'b0, "conc check");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
